// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its stream-side readers.
// Optional parity support elsewhere is enabled with FIFO_STREAM_PARITY_EN.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 8;

  // One stream beat as seen by a downstream consumer.
  typedef struct packed {
    logic [FIFO_DATA_W-1:0] data;
    logic                   parity;
  } stream_beat_t;

  // Number of bits needed to index 'value' entries (value >= 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) begin
        bits = bits + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream bundle for fifo_stream_reader.
// master = the reader, slave = FIFO and downstream consumer side.
// m_parity exists only when FIFO_STREAM_PARITY_EN is defined.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
`ifdef FIFO_STREAM_PARITY_EN
  logic              m_parity;
`endif

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd, m_valid, m_data
`ifdef FIFO_STREAM_PARITY_EN
    , output m_parity
`endif
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd, m_valid, m_data
`ifdef FIFO_STREAM_PARITY_EN
    , input m_parity
`endif
  );
endinterface

// File: rtl/stream_prefetch_buf.sv
// Circular prefetch buffer: count, wrap-around pointers, one write port and
// a valid/ready read port. clr empties it without touching stored bytes.
// Parity storage exists only when FIFO_STREAM_PARITY_EN is defined.
module stream_prefetch_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = clog2(BUF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
`ifdef FIFO_STREAM_PARITY_EN
  input  logic              wr_par,
  output logic              rd_par,
`endif
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = clog2(BUF_DEPTH);

  logic [DATA_W-1:0] mem_r [BUF_DEPTH];
`ifdef FIFO_STREAM_PARITY_EN
  logic              par_r [BUF_DEPTH];
`endif
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              valid_r;
  logic              rd_take_s;

  // Occupancy after this cycle's write and/or transfer.
  always_comb begin
    rd_take_s   = valid_r && rd_ready;
    count_nxt_s = count_r;
    case ({wr_en, rd_take_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and count; clr wins over any write or transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
`ifdef FIFO_STREAM_PARITY_EN
        par_r[i] <= 1'b0;
`endif
      end
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_r[wr_ptr_r] <= wr_data;
`ifdef FIFO_STREAM_PARITY_EN
        par_r[wr_ptr_r] <= wr_par;
`endif
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_take_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  assign rd_valid = valid_r;
  assign rd_data  = mem_r[rd_ptr_r];
  assign count    = count_r;
`ifdef FIFO_STREAM_PARITY_EN
  assign rd_par   = par_r[rd_ptr_r];
`endif
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the 8-deep byte FIFO: issues registered pops,
// absorbs the one-cycle read latency and re-presents bytes as a
// valid/ready stream through a small prefetch buffer.
// Define FIFO_STREAM_PARITY_EN to add m_parity and the chk_parity input.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = clog2(BUF_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master strm,
  input  logic                 flush,
`ifdef FIFO_STREAM_PARITY_EN
  input  logic                 chk_parity,
`endif
  output logic [CNT_W-1:0]     buf_count
);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

  logic           fifo_rd_r;
  logic           inflight_r;
  logic           empty_d_r;
  logic           rd_nxt_s;
  logic [CNT_W:0] demand_s;

`ifdef FIFO_STREAM_PARITY_EN
  logic           wr_par_s;

  // Even parity of one data word.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Parity stored with the returning byte; chk_parity flips it for injection.
  always_comb begin
    wr_par_s = even_parity(strm.fifo_data) ^ chk_parity;
  end
`endif

  // Pop decision: room must cover bytes held, returning and already requested;
  // after a cycle of empty, never pop back-to-back on a possibly stale flag.
  always_comb begin
    demand_s = {1'b0, buf_count}
             + {{CNT_W{1'b0}}, inflight_r}
             + {{CNT_W{1'b0}}, fifo_rd_r};
    rd_nxt_s = 1'b0;
    if (flush || strm.fifo_empty) begin
      rd_nxt_s = 1'b0;
    end else if (fifo_rd_r && empty_d_r) begin
      rd_nxt_s = 1'b0;
    end else if (demand_s < DEPTH_LIM) begin
      rd_nxt_s = 1'b1;
    end else begin
      rd_nxt_s = 1'b0;
    end
  end

  // Pop strobe, in-flight marker and delayed empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_rd_r  <= 1'b0;
      inflight_r <= 1'b0;
      empty_d_r  <= 1'b1;
    end else if (flush) begin
      fifo_rd_r  <= 1'b0;
      inflight_r <= 1'b0;
      empty_d_r  <= strm.fifo_empty;
    end else begin
      fifo_rd_r  <= rd_nxt_s;
      inflight_r <= fifo_rd_r;
      empty_d_r  <= strm.fifo_empty;
    end
  end

  assign strm.fifo_rd = fifo_rd_r;

  stream_prefetch_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .wr_en    (inflight_r),
    .wr_data  (strm.fifo_data),
`ifdef FIFO_STREAM_PARITY_EN
    .wr_par   (wr_par_s),
    .rd_par   (strm.m_parity),
`endif
    .rd_ready (strm.m_ready),
    .rd_valid (strm.m_valid),
    .rd_data  (strm.m_data),
    .count    (buf_count)
  );
endmodule
